// File: rtl/control_fsm.sv
// Multi-cycle main control FSM: FETCH->DECODE->EXEC->(MEM)->(WB) with bounded memory waits.
// Optional feature macro ILLEGAL_TRAP_EN: undefined opcodes halt the machine and set a sticky illegal_op.
module control_fsm #(
  parameter int OPCODE_W    = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_load,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [1:0]          alu_op,
  output logic                alu_src,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                mem_read,
  output logic                mem_write,
  output logic                bus_err,
  output logic                illegal_op,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_R_LO = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_R_HI = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(13);

  localparam bit              TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_lw, is_sw, is_r, is_beq, is_bne, is_jmp, is_legal;
  logic waiting, wait_ready, tmo;

  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_r     = (opcode >= OP_R_LO) && (opcode <= OP_R_HI);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_jmp   = (opcode == OP_JMP);
  assign is_legal = is_lw | is_sw | is_r | is_beq | is_bne | is_jmp;

  // Only FETCH and MEM wait on a memory; each listens to its own ready.
  assign waiting    = (state_q == S_FETCH) || (state_q == S_MEM);
  assign wait_ready = (state_q == S_MEM) ? dmem_ready : imem_ready;
  assign tmo        = TMO_EN && waiting && !wait_ready && (cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d  = illegal_q | ((state_q == S_DECODE) && !is_legal);
  assign illegal_op = illegal_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) illegal_q <= 1'b0;
    else          illegal_q <= illegal_d;
  end
`else
  assign illegal_op = 1'b0;
`endif

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    bus_err    = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo) begin
          bus_err = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          alu_op  = 2'b10;
          alu_src = 1'b1;
          state_d = S_MEM;
        end else if (is_beq || is_bne) begin
          alu_op   = 2'b01;
          pc_src   = 2'b01;
          pc_write = is_beq ? zero : ~zero;
          state_d  = S_FETCH;
        end else if (is_jmp) begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_op    = 2'b10;
        alu_src   = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (dmem_ready) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end else if (tmo) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        state_d    = S_FETCH;
      end
      S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_HALT;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase

    // Wait counter restarts on every state change and on a fetch retry; it never wraps.
    if (!TMO_EN) begin
      cnt_d = '0;
    end else if ((state_d != state_q) || tmo) begin
      cnt_d = '0;
    end else if (waiting && !wait_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Strobes are forced low while reset is held so nothing leaks from an interrupted access.
    if (!reset_n) begin
      imem_req   = 1'b0;
      ir_load    = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_op     = 2'b00;
      alu_src    = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      bus_err    = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Randomized bench for control_fsm: an instruction-level model expands each instruction into its expected cycle trace.
module tb_control_fsm;
  localparam int T = 4;

  typedef struct packed {
    logic       imem_req;
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       bus_err;
    logic       illegal_op;
    logic [2:0] state;
  } ov_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] opcode;
  logic       zero, imem_ready, dmem_ready;
  logic       imem_req, ir_load, pc_write, alu_src, reg_dst, reg_write;
  logic       mem_to_reg, mem_read, mem_write, bus_err, illegal_op;
  logic [1:0] pc_src, alu_op;
  logic [2:0] state;
  ov_t        obs;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  control_fsm #(.OPCODE_W(4), .TIMEOUT_CYC(T), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
    .bus_err(bus_err), .illegal_op(illegal_op), .state(state)
  );

  assign obs = {imem_req, ir_load, pc_write, pc_src, alu_op, alu_src, reg_dst, reg_write,
                mem_to_reg, mem_read, mem_write, bus_err, illegal_op, state};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs are already driven; compare on the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input ov_t e);
    @(negedge clk);
    check(tag, {14'd0, obs}, {14'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    opcode     = 4'($urandom);
    zero       = 1'($urandom);
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
  endtask

  function automatic bit legal_op(input int op);
    return (op <= 9) || (op == 11) || (op == 12) || (op == 13);
  endfunction

  // idly/ddly: cycles before ready (>= T means time out); zf < 0 leaves zero random.
  task automatic run_instr(input int op, input int idly, input int ddly, input int zf);
    ov_t e;
    int  k;
    int  d;
    k = 0;
    d = idly;
    forever begin
      noise();
      imem_ready = (k == d);
      e = '0;
      e.imem_req = 1'b1;
      if (k == d) begin
        e.ir_load  = 1'b1;
        e.pc_write = 1'b1;
        step("fetch_done", e);
        break;
      end
      if (k == T - 1) begin
        e.bus_err = 1'b1;
        step("fetch_timeout", e);
        k = 0;
        d = 0;
      end else begin
        step("fetch_wait", e);
        k++;
      end
    end

    noise();
    opcode = 4'(op);
    e = '0;
    e.state = 3'd1;
    step("decode", e);

    if (!legal_op(op)) begin
`ifdef ILLEGAL_TRAP_EN
      repeat (3) begin
        noise();
        opcode = 4'(op);
        e = '0;
        e.state = 3'd5;
        e.illegal_op = 1'b1;
        step("halt", e);
      end
      noise();
      reset_n = 1'b0;
      e = '0;
      step("halt_reset", e);
      reset_n = 1'b1;
`endif
      return;
    end

    noise();
    opcode = 4'(op);
    if (zf >= 0) zero = zf[0];
    e = '0;
    e.state = 3'd2;
    if (op <= 1) begin
      e.alu_op  = 2'b10;
      e.alu_src = 1'b1;
    end else if (op == 11 || op == 12) begin
      e.alu_op   = 2'b01;
      e.pc_src   = 2'b01;
      e.pc_write = (op == 11) ? zero : ~zero;
    end else if (op == 13) begin
      e.pc_src   = 2'b10;
      e.pc_write = 1'b1;
    end
    step("exec", e);

    if (op >= 2 && op <= 9) begin
      noise();
      opcode = 4'(op);
      e = '0;
      e.state     = 3'd4;
      e.reg_write = 1'b1;
      e.reg_dst   = 1'b1;
      step("wb_r", e);
      return;
    end
    if (op >= 11) return;

    k = 0;
    forever begin
      noise();
      opcode     = 4'(op);
      dmem_ready = (k == ddly);
      e = '0;
      e.state     = 3'd3;
      e.alu_op    = 2'b10;
      e.alu_src   = 1'b1;
      e.mem_read  = (op == 0);
      e.mem_write = (op == 1);
      if (k == ddly) begin
        step("mem_done", e);
        break;
      end
      if (k == T - 1) begin
        e.bus_err = 1'b1;
        step("mem_timeout", e);
        return;
      end
      step("mem_wait", e);
      k++;
    end

    if (op == 0) begin
      noise();
      opcode = 4'(op);
      e = '0;
      e.state      = 3'd4;
      e.reg_write  = 1'b1;
      e.mem_to_reg = 1'b1;
      step("wb_lw", e);
    end
  endtask

  initial begin
    ov_t e;
    reset_n = 1'b0;
    noise();
    @(posedge clk);
    #1;
    e = '0;
    step("reset0", e);
    noise();
    step("reset1", e);
    reset_n = 1'b1;

    run_instr(2, 0, 0, -1);
    run_instr(0, 0, 3, -1);
    run_instr(11, 0, 0, 1);
    run_instr(11, 0, 0, 0);
    run_instr(12, 0, 0, 1);
    run_instr(12, 0, 0, 0);
    run_instr(13, 2, 0, -1);
    run_instr(1, 0, 99, -1);
    run_instr(1, 0, 3, -1);
    run_instr(0, 1, 9, -1);
    run_instr(5, 7, 0, -1);
    run_instr(9, 3, 0, -1);
    run_instr(14, 0, 0, -1);
    run_instr(10, 1, 0, -1);
    run_instr(15, 0, 0, -1);

    // Reset asserted in the middle of a data-memory wait.
    noise(); imem_ready = 1'b1;
    e = '0; e.imem_req = 1'b1; e.ir_load = 1'b1; e.pc_write = 1'b1;
    step("rst_fetch", e);
    noise(); opcode = 4'd0;
    e = '0; e.state = 3'd1;
    step("rst_decode", e);
    noise(); opcode = 4'd0;
    e = '0; e.state = 3'd2; e.alu_op = 2'b10; e.alu_src = 1'b1;
    step("rst_exec", e);
    noise(); opcode = 4'd0; dmem_ready = 1'b0;
    e = '0; e.state = 3'd3; e.alu_op = 2'b10; e.alu_src = 1'b1; e.mem_read = 1'b1;
    step("rst_mem_wait", e);
    noise(); opcode = 4'd0; dmem_ready = 1'b0;
    reset_n = 1'b0;
    e = '0;
    step("rst_mid_mem", e);
    noise();
    step("rst_hold", e);
    reset_n = 1'b1;
    run_instr(0, 0, 0, -1);

    for (int i = 0; i < 300; i++) begin
      run_instr(int'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 5)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
